// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, requester indices and the access legality check.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned DEPTH_DEF       = 256;
    localparam int unsigned CNT_W           = 4;

    // Misaligned words and words running past the end of memory are rejected.
    function automatic logic addr_illegal(
        input logic [31:0] addr,
        input int unsigned depth
    );
        logic [31:0] last_ok;
        last_ok = 32'(depth - 4);
        return (addr[1:0] != 2'b00) || (addr > last_ok);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker for the data-memory arbiter.
// On a tie the requester that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        gnt   = 1'b0;
        valid = |req;
        unique case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU data port and a DMA/debug port onto one word memory.
// Transactions are latched at grant and run IDLE -> ACCESS -> RESP.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             port_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             ack0_q;
    logic             ack1_q;
    logic             err0_q;
    logic             err1_q;
    logic             rd_q;
    logic             wr_q;
    logic             busy_q;

    logic             gnt;
    logic             gnt_valid;
    logic             sel_we_d;
    logic [31:0]      sel_addr_d;
    logic [31:0]      sel_wdata_d;
    logic             illegal_d;

    rr_arb2 u_rr (
        .req   ({p1_req, p0_req}),
        .last  (last_q),
        .gnt   (gnt),
        .valid (gnt_valid)
    );

    always_comb begin
        sel_we_d    = p0_we;
        sel_addr_d  = p0_addr;
        sel_wdata_d = p0_wdata;
        if (gnt == PORT_DMA) begin
            sel_we_d    = p1_we;
            sel_addr_d  = p1_addr;
            sel_wdata_d = p1_wdata;
        end
        illegal_d = addr_illegal(sel_addr_d, DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= PORT_DMA;
            port_q  <= PORT_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        last_q  <= gnt;
                        port_q  <= gnt;
                        we_q    <= sel_we_d;
                        addr_q  <= sel_addr_d;
                        wdata_q <= sel_wdata_d;
                        busy_q  <= 1'b1;
                        if (illegal_d) begin
                            // Rejected: respond next cycle, never touch memory.
                            state_q <= RESP;
                            rdata_q <= '0;
                            ack0_q  <= (gnt == PORT_CPU);
                            ack1_q  <= (gnt == PORT_DMA);
                            err0_q  <= (gnt == PORT_CPU);
                            err1_q  <= (gnt == PORT_DMA);
                        end else begin
                            state_q <= ACCESS;
                            cnt_q   <= CNT_LOAD;
                            rd_q    <= ~sel_we_d;
                            wr_q    <= sel_we_d;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        ack0_q  <= (port_q == PORT_CPU);
                        ack1_q  <= (port_q == PORT_DMA);
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign p0_ack    = ack0_q;
    assign p1_ack    = ack1_q;
    assign p0_err    = err0_q;
    assign p1_err    = err1_q;
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = rd_q;
    assign mem_write = wr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a small word memory model.
// Drivers queue expected responses; a negedge monitor checks them.
module tb_dmem_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;

    dmem_arbiter #(.WAIT_CYCLES(W), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
        mem[4] = 32'hDEAD_BEEF;
    end
    always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[7:2]];

    typedef struct {
        bit          port;
        bit          we;
        bit          err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          nstb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   stb_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stb_cnt = 0;
        end else begin
            if (mem_read && mem_write) chk("strobe_excl", 1, 0);
            if (mem_read || mem_write) begin
                stb_cnt++;
                if (sb.size() == 0) begin
                    chk("strobe_unexpected", 1, 0);
                end else begin
                    chk("mem_addr", mem_addr, sb[0].addr);
                    chk("mem_write", {31'b0, mem_write}, {31'b0, sb[0].we});
                    if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
                end
            end
            if (p0_ack || p1_ack) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_port", {30'b0, p1_ack, p0_ack},
                        e.port ? 32'd2 : 32'd1);
                    chk("ack_err", {30'b0, p1_err, p0_err},
                        e.err ? (e.port ? 32'd2 : 32'd1) : 32'd0);
                    if (!e.we || e.err) chk("rdata", rdata, e.rdata);
                    chk("strobe_cycles", stb_cnt, e.nstb);
                end
                stb_cnt = 0;
            end
        end
    end

    task automatic push(bit port, bit we, logic [31:0] addr,
                        logic [31:0] wdata, logic [31:0] rd, bit err);
        exp_t e;
        e.port = port; e.we = we; e.err = err;
        e.addr = addr; e.wdata = wdata;
        e.rdata = err ? 32'h0 : rd;
        e.nstb = err ? 0 : W;
        sb.push_back(e);
    endtask

    task automatic drive(bit port, bit req, bit we,
                         logic [31:0] addr, logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic wait_ack(bit port, output int n);
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < 64) begin
            @(posedge clk); #1;
            n++;
            if (port ? p1_ack : p0_ack) seen = 1;
        end
        if (!seen) begin
            chk("ack_timeout", 0, 1);
            n = -1;
        end
    endtask

    task automatic txn(bit port, bit we, logic [31:0] addr,
                       logic [31:0] wdata, logic [31:0] rd,
                       bit err, bit hijack = 0);
        int  n;
        bit  seen;
        push(port, we, addr, wdata, rd, err);
        @(negedge clk);
        drive(port, 1, we, addr, wdata);
        seen = 0;
        n = 0;
        while (!seen && n < 64) begin
            @(posedge clk); #1;
            n++;
            if (port ? p1_ack : p0_ack) seen = 1;
            else if (hijack && n == 1) drive(port, 0, we, 32'h40, 32'hFFFF_FFFF);
        end
        chk("latency", n, err ? 1 : W + 1);
        drive(port, 0, 0, 32'h0, 32'h0);
        @(posedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 0);
        chk("rst_acks", {28'b0, p0_ack, p1_ack, p0_err, p1_err}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;

        txn(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        txn(1, 1, 32'h20, 32'h1234_5678, 32'h0, 0);
        txn(0, 0, 32'h20, 32'h0, 32'h1234_5678, 0);
        txn(1, 1, 32'hFC, 32'hCAFE_F00D, 32'h0, 0);
        txn(0, 0, 32'hFC, 32'h0, 32'hCAFE_F00D, 0);
        txn(0, 0, 32'h13, 32'h0, 32'h0, 1);
        txn(0, 0, 32'hFE, 32'h0, 32'h0, 1);
        txn(1, 1, 32'h100, 32'h5555_AAAA, 32'h0, 1);
        txn(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 1);

        // Reset in the second ACCESS cycle aborts without an ack.
        push(0, 0, 32'h24, 32'h0, 32'hA500_0009, 0);
        @(negedge clk);
        drive(0, 1, 0, 32'h24, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_strobes", {30'b0, mem_read, mem_write}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_ack", {30'b0, p0_ack, p1_ack}, 0);
        drive(0, 0, 0, 32'h0, 32'h0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        txn(0, 0, 32'h24, 32'h0, 32'hA500_0009, 0);

        // Tie after reset, then p0 re-requests back-to-back.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        push(1, 0, 32'h20, 32'h0, 32'h1234_5678, 0);
        push(0, 0, 32'h24, 32'h0, 32'hA500_0009, 0);
        @(negedge clk);
        drive(0, 1, 0, 32'h10, 32'h0);
        drive(1, 1, 0, 32'h20, 32'h0);
        wait_ack(0, n);
        chk("tie_first_lat", n, W + 1);
        p0_addr = 32'h24;
        wait_ack(1, n);
        p1_req = 1'b0;
        wait_ack(0, n);
        p0_req = 1'b0;

        repeat (4) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, 2, memory access cycles per transaction (legal range 1..15).
REQ-002 Parameter: DEPTH, 256, data memory size in bytes.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-005 Port: p0_req, p1_req  input  1 each  transaction request from the CPU data port (p0) or the DMA/debug port (p1).
REQ-006 Port: p0_we, p1_we  input  1 each  1 = word write, 0 = word read.
REQ-007 Port: p0_addr, p1_addr  input  32 each  byte address of the word.
REQ-008 Port: p0_wdata, p1_wdata  input  32 each  big-endian write word.
REQ-009 Port: p0_ack, p1_ack  output  1 each  one-cycle completion pulse.
REQ-010 Port: p0_err, p1_err  output  1 each  valid with ack; 1 = rejected access.
REQ-011 Port: rdata  output  32  read word; valid when any ack is high and we was 0.
REQ-012 Port: mem_addr, mem_wdata  output  32 each  to data memory.
REQ-013 Port: mem_read, mem_write  output  1 each  memory strobes.
REQ-014 Port: mem_rdata  input  32  from data memory.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS on a legal grant, IDLE->RESP on an illegal grant, ACCESS->RESP when the wait counter reaches 0, RESP->IDLE unconditionally.
REQ-017 In IDLE with exactly one req high, that port SHALL be granted; with both high, the port not granted last SHALL win (round-robin).
REQ-018 On grant the block SHALL latch we, addr, wdata and port index; later changes to requester inputs SHALL not affect the transaction.
REQ-019 An access with addr[1:0] != 0 or addr > DEPTH-4 SHALL be illegal: no memory strobe, ack with err=1, rdata = 0.
REQ-020 In ACCESS, mem_addr/mem_wdata SHALL hold the latched values and exactly one of mem_read/mem_write SHALL be high for exactly WAIT_CYCLES consecutive cycles; the wait counter SHALL load WAIT_CYCLES-1 on grant and decrement once per cycle.
REQ-021 mem_read and mem_write SHALL never be high simultaneously, and both SHALL be 0 outside ACCESS.
REQ-022 rdata SHALL capture mem_rdata on the last ACCESS cycle and hold until the next read capture.
REQ-023 In RESP, only the granted port's ack SHALL pulse for one cycle; latency from req sampled in IDLE to ack SHALL be WAIT_CYCLES+1 cycles (legal), 1 cycle (illegal).
REQ-024 A requester SHALL hold req until ack; req still high in the RESP cycle SHALL not be re-granted until IDLE of the following cycle.
REQ-025 A req deasserted during ACCESS SHALL not abort the transaction; ack still pulses.
REQ-026 The round-robin pointer SHALL update only on grant, including illegal grants.

Reset
REQ-027 With rst_n low at a clock edge: state IDLE, counter 0, pointer = p1 (so p0 wins the first tie), all ack/err/strobes/busy 0, rdata 0, mem_addr/mem_wdata 0.
REQ-028 Reset asserted mid-ACCESS SHALL drop strobes the next cycle and SHALL produce no ack.

Structure
REQ-029 A shared package dmem_pkg SHALL hold the state enum, port-index constants (PORT_CPU=0, PORT_DMA=1) and the WAIT_CYCLES default.
REQ-030 The two-way round-robin picker SHALL be a sub-module rr_arb2 (inputs req[1:0], last; outputs gnt index, valid).

Verification
REQ-031 Single read p0 addr 0x10, memory word 0xDEADBEEF, WAIT_CYCLES=2 -> mem_read high 2 cycles, p0_ack 3 cycles after req, rdata 0xDEADBEEF, err 0.
REQ-032 p0 and p1 req in the same cycle after reset -> p0 served first, then p1; back-to-back tie afterwards -> p1 served, then p0.
REQ-033 p1 write 0x12345678 to 0x20 -> mem_write high 2 cycles with mem_addr 0x20, mem_wdata 0x12345678; subsequent p0 read of 0x20 returns 0x12345678.
REQ-034 p0 read addr 0x13 and addr 0xFE -> p0_ack with p0_err=1 one cycle after grant, no strobes, rdata 0.
REQ-035 rst_n low during second ACCESS cycle -> strobes 0 next cycle, no ack, busy 0; next request served normally.
REQ-036 p0 drops req and changes addr during ACCESS -> mem_addr unchanged, p0_ack still pulses.
